nvdla_dbb_rd_arb: RTL

NVDLA_DBB_RD_ARB -- requirements
Module: nvdla_dbb_rd_arb

---
 rtl/nvdla_dbb_rd_arb_if.sv | 43 ++++
 rtl/nvdla_dbb_rd_arb.sv | 122 ++++++++++++
 2 files changed

// File: rtl/nvdla_dbb_rd_arb_if.sv
// Bundle of the two upstream AR/R requester ports and the downstream DBB AR/R port.
interface nvdla_dbb_rd_arb_if #(
  parameter int AR_ADDR_WIDTH = 32,
  parameter int R_DATA_WIDTH  = 64
);
  logic [1:0]                    s_ar_valid;
  logic [1:0]                    s_ar_ready;
  logic [1:0][3:0]               s_ar_len;
  logic [1:0][AR_ADDR_WIDTH-1:0] s_ar_addr;
  logic [1:0][7:0]               s_ar_id;
  logic [1:0]                    s_r_valid;
  logic [1:0]                    s_r_ready;
  logic                          s_r_last;
  logic [R_DATA_WIDTH-1:0]       s_r_data;
  logic [7:0]                    s_r_id;

  logic                          m_ar_valid;
  logic                          m_ar_ready;
  logic [3:0]                    m_ar_len;
  logic [AR_ADDR_WIDTH-1:0]      m_ar_addr;
  logic [7:0]                    m_ar_id;
  logic                          m_r_valid;
  logic                          m_r_ready;
  logic                          m_r_last;
  logic [R_DATA_WIDTH-1:0]       m_r_data;
  logic [7:0]                    m_r_id;

  // Arbiter side
  modport master (
    input  s_ar_valid, s_ar_len, s_ar_addr, s_ar_id, s_r_ready,
    output s_ar_ready, s_r_valid, s_r_last, s_r_data, s_r_id,
    output m_ar_valid, m_ar_len, m_ar_addr, m_ar_id, m_r_ready,
    input  m_ar_ready, m_r_valid, m_r_last, m_r_data, m_r_id
  );

  // Requesters and downstream memory side
  modport slave (
    output s_ar_valid, s_ar_len, s_ar_addr, s_ar_id, s_r_ready,
    input  s_ar_ready, s_r_valid, s_r_last, s_r_data, s_r_id,
    input  m_ar_valid, m_ar_len, m_ar_addr, m_ar_id, m_r_ready,
    output m_ar_ready, m_r_valid, m_r_last, m_r_data, m_r_id
  );
endinterface

// File: rtl/nvdla_dbb_rd_arb.sv
// Two-requester DBB read arbiter: round-robin AR grant with per-requester
// outstanding-burst limits, combinational R routing by ID bit 7.
module nvdla_dbb_rd_arb #(
  parameter int AR_ADDR_WIDTH   = 32,
  parameter int R_DATA_WIDTH    = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nvdla_dbb_rd_arb_if.master   bus,
  output logic                 err,
  output logic [1:0][3:0]      outstanding
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                   state, state_nxt;
  logic                     grant, last_grant, pick;
  logic                     capture, ar_fire, r_done, sel;
  logic [1:0]               elig, inc, dec;
  logic [3:0]               len_q;
  logic [AR_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]               id_q;
  logic [R_DATA_WIDTH-1:0]  r_data;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++)
      elig[i] = bus.s_ar_valid[i] && (outstanding[i] < MAX_CNT);
  end

  // Tie goes to whichever requester was not granted last.
  assign pick = (elig == 2'b11) ? ~last_grant : elig[1];

  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    ar_fire        = 1'b0;
    bus.s_ar_ready = '0;
    case (state)
      IDLE: begin
        if (|elig) begin
          capture              = 1'b1;
          bus.s_ar_ready[pick] = 1'b1;
          state_nxt            = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ar_ready) begin
          ar_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      len_q      <= '0;
      addr_q     <= '0;
      id_q       <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        grant  <= pick;
        len_q  <= bus.s_ar_len[pick];
        addr_q <= bus.s_ar_addr[pick];
        id_q   <= {pick, bus.s_ar_id[pick][6:0]};
      end
      if (ar_fire)
        last_grant <= grant;
    end
  end

  assign bus.m_ar_valid = (state == ISSUE);
  assign bus.m_ar_len   = len_q;
  assign bus.m_ar_addr  = addr_q;
  assign bus.m_ar_id    = id_q;

  assign sel           = bus.m_r_id[7];
  assign bus.s_r_valid = bus.m_r_valid ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_r_ready = bus.s_r_ready[sel];
  assign r_data        = bus.m_r_data;
  assign bus.s_r_data  = r_data;
  assign bus.s_r_last  = bus.m_r_last;
  assign bus.s_r_id    = {1'b0, bus.m_r_id[6:0]};
  assign r_done        = bus.m_r_valid && bus.m_r_ready && bus.m_r_last;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      inc[i] = ar_fire && (grant == 1'(i));
      dec[i] = r_done && (sel == 1'(i));
    end
  end

  // Simultaneous inc/dec cancel; underflow holds at zero and flags err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (inc[i] && !dec[i])
          outstanding[i] <= outstanding[i] + 4'd1;
        else if (dec[i] && !inc[i]) begin
          if (outstanding[i] == 4'd0)
            err <= 1'b1;
          else
            outstanding[i] <= outstanding[i] - 4'd1;
        end
      end
      if (capture && bus.s_ar_id[pick][7])
        err <= 1'b1;
    end
  end

endmodule
